// File: rtl/io_input_responder.sv
// io_input_responder
//
// Services one user-input request from the CPU control unit. The raw push-button,
// data switches and halt switch are synchronized into the clock domain. The button
// is debounced. A small handshake FSM waits for a fresh debounced press, captures
// the switches on that press, waits for the release, and then pulses io_ack.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   reset        asynchronous active-low reset
//   io_req       request level from the CPU, held high until io_ack is seen
//   button_in    raw push-button, active-low (0 = pressed)
//   data_keys    raw 7-bit two's complement switch value
//   halt_key_in  raw halt switch, active-high
//   io_busy      high while a request is being serviced
//   io_ack       one-cycle pulse: io_data/io_halt valid for this request
//   io_data      captured data_keys, sign-extended to 16 bits
//   io_halt      halt switch value captured with io_data
//   btn_db       debounced button level, active-high (1 = pressed)
module io_input_responder #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_req,
    input  logic        button_in,
    input  logic [6:0]  data_keys,
    input  logic        halt_key_in,
    output logic        io_busy,
    output logic        io_ack,
    output logic [15:0] io_data,
    output logic        io_halt,
    output logic        btn_db
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ARM          = 3'd1,
        WAIT_PRESS   = 3'd2,
        WAIT_RELEASE = 3'd3,
        ACK          = 3'd4,
        DONE         = 3'd5
    } state_t;

    function automatic logic signed [15:0] sext_keys(input logic signed [6:0] k);
        return {{9{k[6]}}, k};
    endfunction

    logic              btn_p0, btn_p1;
    logic signed [6:0] keys_p0, keys_p1;
    logic              halt_p0, halt_p1;
    logic              btn_pressed;
    logic [CNT_W-1:0]  db_cnt;
    logic              btn_db_q;
    state_t            state_q, state_d;
    logic              capture;
    logic signed [15:0] io_data_q;
    logic              io_halt_q;

    // Stage p0/p1: two-flop synchronizers. The button resets to its released level (1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_p0  <= 1'b1;
            btn_p1  <= 1'b1;
            keys_p0 <= '0;
            keys_p1 <= '0;
            halt_p0 <= 1'b0;
            halt_p1 <= 1'b0;
        end else begin
            btn_p0  <= button_in;
            btn_p1  <= btn_p0;
            keys_p0 <= data_keys;
            keys_p1 <= keys_p0;
            halt_p0 <= halt_key_in;
            halt_p1 <= halt_p0;
        end
    end

    assign btn_pressed = ~btn_p1;

    // Debounce: count consecutive cycles the synchronized level disagrees with btn_db.
    // Any agreement clears the count, so a bounce restarts the stability window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt   <= '0;
            btn_db_q <= 1'b0;
        end else if (btn_pressed != btn_db_q) begin
            if (db_cnt == CNT_LAST) begin
                btn_db_q <= ~btn_db_q;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign btn_db = btn_db_q;

    // Handshake FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        io_busy = 1'b0;
        io_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_req) state_d = ARM;
            end
            ARM: begin
                io_busy = 1'b1;
                // A press already held when the request arrived must be released first.
                if (!io_req)        state_d = IDLE;
                else if (!btn_db_q) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                io_busy = 1'b1;
                // Capture happens on a press even if the request is being dropped now.
                capture = btn_db_q;
                if (!io_req)       state_d = IDLE;
                else if (btn_db_q) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                io_busy = 1'b1;
                if (!io_req)        state_d = IDLE;
                else if (!btn_db_q) state_d = ACK;
            end
            ACK: begin
                io_busy = 1'b1;
                io_ack  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!io_req) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture register: only the press cycle or reset changes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_data_q <= '0;
            io_halt_q <= 1'b0;
        end else if (capture) begin
            io_data_q <= sext_keys(keys_p1);
            io_halt_q <= halt_p1;
        end
    end

    assign io_data = io_data_q;
    assign io_halt = io_halt_q;

endmodule

// File: tb/tb_io_input_responder.sv
module tb_io_input_responder;

    localparam int DB = 4;

    logic        clk;
    logic        reset;
    logic        io_req;
    logic        button_in;
    logic [6:0]  data_keys;
    logic        halt_key_in;
    logic        io_busy;
    logic        io_ack;
    logic [15:0] io_data;
    logic        io_halt;
    logic        btn_db;

    int errors = 0;
    int checks = 0;

    logic [16:0] sb_q[$];
    bit          hist[$];
    bit          mdb;
    logic        prev_ack;
    logic [15:0] exp_io_data;
    logic        exp_io_halt;

    io_input_responder #(.DB_CYCLES(DB)) dut (
        .clk(clk),
        .reset(reset),
        .io_req(io_req),
        .button_in(button_in),
        .data_keys(data_keys),
        .halt_key_in(halt_key_in),
        .io_busy(io_busy),
        .io_ack(io_ack),
        .io_data(io_data),
        .io_halt(io_halt),
        .btn_db(btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value of a 7-bit two's complement number, written out as a 16-bit quantity.
    function automatic logic [15:0] tb_sext(input logic [6:0] k);
        int v;
        v = int'(k);
        if (v > 63) v = v - 128;
        return 16'(v);
    endfunction

    // Debounce reference: the pressed level as seen two edges late; btn_db flips
    // once the last DB such delayed samples all disagree with it.
    always @(posedge clk or negedge reset) begin
        bit all_diff;
        if (!reset) begin
            hist.delete();
            for (int i = 0; i < DB + 3; i++) hist.push_back(1'b0);
            mdb = 1'b0;
        end else begin
            hist.push_back(~button_in);
            if (hist.size() > DB + 3) void'(hist.pop_front());
            all_diff = 1'b1;
            for (int i = 1; i <= DB; i++)
                if (hist[i] == mdb) all_diff = 1'b0;
            if (all_diff) mdb = ~mdb;
        end
    end

    // Monitor: debounced level every cycle, and scoreboard pop on every io_ack.
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset) begin
            check_bit("btn_db_model", btn_db, mdb);
            if (io_ack) begin
                check_bit("ack_busy", io_busy, 1'b1);
                check_bit("ack_single_cycle", prev_ack, 1'b0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got io_ack=1 (io_data=%h) expected no ack at %0t", io_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    check_word("ack_data", io_data, e[15:0]);
                    check_bit("ack_halt", io_halt, e[16]);
                end
            end
            prev_ack = io_ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Drive the button towards `pressed`, bouncing `toggles` times first (even count).
    // run = 0 picks random bounce run lengths shorter than the debounce window.
    task automatic drive_level(input bit pressed, input int toggles, input int run);
        int n;
        for (int i = 0; i < toggles; i++) begin
            button_in = (i % 2 == 0) ? ~pressed : pressed;
            n = (run != 0) ? run : int'($urandom_range(1, DB - 1));
            repeat (n) @(negedge clk);
        end
        button_in = ~pressed;
    endtask

    task automatic wait_db(input logic lvl, input int budget, input string name);
        int n = 0;
        while (btn_db !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_bit(name, btn_db, lvl);
    endtask

    task automatic wait_ack(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (io_ack !== 1'b1 && n < budget);
        check_bit(name, io_ack, 1'b1);
    endtask

    // One complete request. Entered at a negedge with io_req low and button released.
    task automatic do_txn(input logic [6:0] keys, input logic halt, input bit stale,
                          input int toggles, input int hold, input bit timed);
        if (stale) begin
            data_keys = keys ^ 7'h5A;
            drive_level(1'b1, 0, 0);
            wait_db(1'b1, 40, "stale_db_up");
        end else begin
            data_keys   = keys;
            halt_key_in = halt;
        end
        io_req = 1'b1;
        @(negedge clk);
        check_bit("busy_arm", io_busy, 1'b1);
        if (stale) begin
            repeat ($urandom_range(3, 8)) @(negedge clk);
            check_word("stale_no_capture", io_data, exp_io_data);
            drive_level(1'b0, toggles, 0);
            wait_db(1'b0, 40, "stale_db_down");
            data_keys   = keys;
            halt_key_in = halt;
            repeat (3) @(negedge clk);
        end else begin
            repeat (2) @(negedge clk);
        end
        sb_q.push_back({halt, tb_sext(keys)});
        drive_level(1'b1, toggles, timed ? 2 : 0);
        if (timed) begin
            repeat (5) @(negedge clk);
            check_bit("db_not_yet_risen", btn_db, 1'b0);
            @(negedge clk);
            check_bit("db_rise_latency", btn_db, 1'b1);
        end else begin
            wait_db(1'b1, 40, "press_db_up");
        end
        repeat (5) @(negedge clk);
        exp_io_data = tb_sext(keys);
        exp_io_halt = halt;
        check_word("captured_data", io_data, exp_io_data);
        data_keys   = 7'($urandom);
        halt_key_in = 1'($urandom);
        drive_level(1'b0, toggles, 0);
        wait_ack(60, "ack_seen");
        @(negedge clk);
        check_bit("busy_done", io_busy, 1'b0);
        check_bit("ack_done_low", io_ack, 1'b0);
        check_word("data_held_after_ack", io_data, exp_io_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_bit("done_hold_busy", io_busy, 1'b0);
        end
        io_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        io_req      = 1'b0;
        button_in   = 1'b1;
        data_keys   = 7'h00;
        halt_key_in = 1'b0;
        exp_io_data = 16'h0000;
        exp_io_halt = 1'b0;
        prev_ack    = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("rst_busy", io_busy, 1'b0);
        check_bit("rst_ack", io_ack, 1'b0);
        check_word("rst_data", io_data, 16'h0000);
        check_bit("rst_halt", io_halt, 1'b0);
        check_bit("rst_btn_db", btn_db, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic request with exact latency checks on capture and acknowledge.
        data_keys = 7'h05;
        io_req    = 1'b1;
        @(negedge clk);
        check_bit("basic_busy", io_busy, 1'b1);
        repeat (2) @(negedge clk);
        sb_q.push_back({1'b0, 16'h0005});
        button_in = 1'b0;
        repeat (5) @(negedge clk);
        check_bit("basic_db_early", btn_db, 1'b0);
        @(negedge clk);
        check_bit("basic_db_rise", btn_db, 1'b1);
        check_word("basic_not_captured", io_data, 16'h0000);
        @(negedge clk);
        check_word("basic_capture", io_data, 16'h0005);
        exp_io_data = 16'h0005;
        repeat (3) @(negedge clk);
        button_in = 1'b1;
        repeat (6) @(negedge clk);
        check_bit("basic_ack_early", io_ack, 1'b0);
        @(negedge clk);
        check_bit("basic_ack", io_ack, 1'b1);
        @(negedge clk);
        check_bit("basic_busy_done", io_busy, 1'b0);
        io_req = 1'b0;
        @(negedge clk);

        // Negative value with halt.
        do_txn(7'h7E, 1'b1, 1'b0, 0, 0, 1'b0);
        check_word("neg_data", io_data, 16'hFFFE);
        check_bit("neg_halt", io_halt, 1'b1);

        // Bouncing press: ten 2-cycle runs, then a clean level.
        do_txn(7'h2A, 1'b0, 1'b0, 10, 0, 1'b1);

        // Press held from before the request.
        do_txn(7'h11, 1'b0, 1'b1, 0, 0, 1'b0);
        check_word("stale_data", io_data, 16'h0011);

        // Handshake: io_req held after the ack.
        do_txn(7'h40, 1'b1, 1'b0, 0, 10, 1'b0);

        // Abort in WAIT_RELEASE.
        data_keys   = 7'h23;
        halt_key_in = 1'b1;
        io_req      = 1'b1;
        repeat (3) @(negedge clk);
        button_in = 1'b0;
        wait_db(1'b1, 40, "abort_db_up");
        repeat (2) @(negedge clk);
        io_req = 1'b0;
        @(negedge clk);
        check_bit("abort_idle", io_busy, 1'b0);
        exp_io_data = 16'h0023;
        exp_io_halt = 1'b1;
        data_keys   = 7'h55;
        button_in   = 1'b1;
        wait_db(1'b0, 40, "abort_db_down");
        repeat (8) @(negedge clk);
        check_word("abort_data_kept", io_data, exp_io_data);
        check_bit("abort_halt_kept", io_halt, exp_io_halt);

        // Randomized requests.
        for (int t = 0; t < 8; t++) begin
            do_txn(7'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   2 * int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset asserted in WAIT_PRESS.
        data_keys = 7'h33;
        io_req    = 1'b1;
        repeat (3) @(negedge clk);
        button_in = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_bit("midrst_busy", io_busy, 1'b0);
        check_bit("midrst_ack", io_ack, 1'b0);
        check_word("midrst_data", io_data, 16'h0000);
        check_bit("midrst_halt", io_halt, 1'b0);
        check_bit("midrst_btn_db", btn_db, 1'b0);
        io_req    = 1'b0;
        button_in = 1'b1;
        repeat (2) @(negedge clk);
        reset       = 1'b1;
        exp_io_data = 16'h0000;
        exp_io_halt = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("postrst_idle", io_busy, 1'b0);
        check_word("postrst_data", io_data, 16'h0000);

        // Service resumes after reset.
        do_txn(7'h3F, 1'b0, 1'b0, 4, 1, 1'b0);

        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_acks: got %0d outstanding expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
